compare_data_chk: RTL
=====================

Name: compare_data_chk

Overview:
Parametrised read-back checker for the DDR2 test path; generalises the single-word compare into a buffered multi-byte checker. Expected write data (data_in/din_vd) is queued in an internal FIFO. Read-back words (dout_fifo/dout_vd) are compared in order against the queue head. Reports per-byte mismatch, error/compare counts, first-error capture, sticky status and an optional stop-on-error mode.

Parameters:
DATA_W, 32, data width in bits; multiple of 8.
DEPTH, 16, expected-data FIFO depth in words; power of 2, at least 2.
CNT_W, 16, width of the compare counter, error counter and index counter.
STOP_ON_ERR, 0, 1 = halt comparisons after first mismatch; 0 = keep running.

Ports:
sys_clk  in  1  system clock, all logic on rising edge.
reset_n  in  1  asynchronous active-low reset.
clear  in  1  sync clear: empties FIFO, zeroes counters/status, returns to IDLE.
enable  in  1  1 = checker active.
data_in  in  DATA_W  expected data.
din_vd  in  1  data_in valid (push).
dout_fifo  in  DATA_W  read-back data.
dout_vd  in  1  dout_fifo valid (compare/pop).
data_error  out  1  registered 1-cycle pulse per mismatching compare.
err_byte_mask  out  DATA_W/8  bit i set = byte i mismatched on the last compare; held until next compare.
err_sticky  out  1  set on any mismatch or underflow.
ovf  out  1  sticky: push attempted while FIFO full.
udf  out  1  sticky: dout_vd while FIFO empty.
halted  out  1  state is HALT.
err_count  out  CNT_W  mismatches plus underflows, saturating.
cmp_count  out  CNT_W  compares performed, saturating.
first_err_exp  out  DATA_W  expected word at first error.
first_err_act  out  DATA_W  actual word at first error.
first_err_idx  out  CNT_W  cmp_count value (0-based) at first error.
fifo_level  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset_n=0, async): all outputs 0, FIFO empty, state IDLE. clear=1 has the same effect synchronously and has priority over all other inputs in that cycle.
- States:
  - IDLE -> RUN when enable=1.
  - RUN -> IDLE when enable=0; FIFO contents and counters are retained.
  - RUN -> HALT on error when STOP_ON_ERR=1.
  - HALT exits only via clear or reset.
- In IDLE and HALT, din_vd and dout_vd are ignored; no push, no pop, no count changes.
- Push in RUN: din_vd=1 with FIFO not full writes data_in. When full and no pop in the same cycle, the word is dropped and ovf is set. Full with a simultaneous pop: the push is accepted.
- Compare in RUN: dout_vd=1 with FIFO not empty (occupancy at the start of the cycle) pops the head and compares it with dout_fifo. No bypass: a word pushed in the same cycle is not visible to that compare.
- Latency: data_error, err_byte_mask, counters and first-error registers update on the edge after the compare cycle (1 cycle).
- Byte mask: byte i mismatches when head[8i+7:8i] differs from dout_fifo[8i+7:8i]. data_error = OR of the mask bits.
- cmp_count increments on every compare.
- Underflow: dout_vd=1 with FIFO empty sets udf and err_sticky, increments err_count, pulses data_error, and leaves err_byte_mask all ones. No pop occurs and cmp_count does not increment.
- First error is captured once, while err_sticky=0:
  - first_err_exp and first_err_act take the compared words (exp=0 on underflow).
  - first_err_idx takes the pre-increment cmp_count.
- Counters saturate at all ones, with no wrap.
- FIFO pointers wrap modulo DEPTH. fifo_level ranges 0 to DEPTH.
- When STOP_ON_ERR=1, the error-causing compare is fully reported, and halted=1 on the same edge as data_error.

Test Plan:
- Reset then enable; push 0x00000001 to 0x00000004, then read back the same 4 words -> data_error never 1, cmp_count=4, err_count=0, fifo_level=0.
- Push 0xAABBCCDD, read back 0xAABBCC00 -> one cycle later: data_error pulse, err_byte_mask=4'b0001, first_err_exp=0xAABBCCDD, first_err_act=0xAABBCC00, first_err_idx=0.
- STOP_ON_ERR=1; push 3 words, second one corrupted -> halted=1 after compare 2; third dout_vd ignored; cmp_count=2, fifo_level=1; clear -> all zero, IDLE.
- Push 17 words with DEPTH=16 -> ovf=1, fifo_level=16. Full with simultaneous push and pop -> level stays 16, no new ovf.
- dout_vd with empty FIFO -> udf=1, err_count=1, err_byte_mask=4'hF, cmp_count=0. Push and dout_vd in the same cycle on an empty FIFO -> also an underflow, and fifo_level=1 afterwards.
- CNT_W=4; 20 mismatching compares -> err_count and cmp_count hold at 15. Assert reset_n mid-stream -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/compare_data_chk_if.sv
// -----------------------------------------------------------------------------
// compare_data_chk_if
// Stimulus-side bus of the read-back checker: the expected-data push channel
// and the read-back compare channel.
//   data_in   : expected write data
//   din_vd    : data_in valid (push into the expected-data queue)
//   dout_fifo : read-back data
//   dout_vd   : dout_fifo valid (compare against the queue head and pop it)
// master drives the bus (traffic source / bench), slave is the checker.
// -----------------------------------------------------------------------------
interface compare_data_chk_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] data_in;
    logic              din_vd;
    logic [DATA_W-1:0] dout_fifo;
    logic              dout_vd;

    modport master (output data_in, din_vd, dout_fifo, dout_vd);
    modport slave  (input  data_in, din_vd, dout_fifo, dout_vd);
endinterface

// File: rtl/compare_data_chk.sv
// -----------------------------------------------------------------------------
// compare_data_chk
// Buffered read-back checker for the DDR2 test path. Expected words are queued
// in an internal FIFO; every read-back word is compared, in order, with the
// queue head. Per-byte mismatch, saturating error/compare counters, first-error
// capture, sticky status and an optional stop-on-error mode are reported.
//
// Ports:
//   sys_clk        : clock, all logic on the rising edge
//   reset_n        : asynchronous active-low reset
//   clear          : synchronous clear (FIFO, counters, status, state -> IDLE)
//   enable         : 1 = checker active (IDLE -> RUN, RUN -> IDLE when low)
//   bus            : push / compare channel (compare_data_chk_if.slave)
//   data_error     : 1-cycle pulse per mismatching compare or underflow
//   err_byte_mask  : per-byte mismatch of the last compare (all ones on underflow)
//   err_sticky     : any mismatch or underflow seen
//   ovf / udf      : sticky push-while-full / compare-while-empty
//   halted         : checker stopped after an error (STOP_ON_ERR = 1)
//   err_count      : mismatches plus underflows, saturating
//   cmp_count      : compares performed, saturating
//   first_err_exp/act/idx : words and compare index of the first error
//   fifo_level     : current FIFO occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module compare_data_chk #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int CNT_W       = 16,
    parameter int STOP_ON_ERR = 0
) (
    input  logic                     sys_clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     enable,
    compare_data_chk_if.slave        bus,
    output logic                     data_error,
    output logic [DATA_W/8-1:0]      err_byte_mask,
    output logic                     err_sticky,
    output logic                     ovf,
    output logic                     udf,
    output logic                     halted,
    output logic [CNT_W-1:0]         err_count,
    output logic [CNT_W-1:0]         cmp_count,
    output logic [DATA_W-1:0]        first_err_exp,
    output logic [DATA_W-1:0]        first_err_act,
    output logic [CNT_W-1:0]         first_err_idx,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int NB = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [NB-1:0] byte_diff(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic [NB-1:0] m;
        for (int i = 0; i < NB; i++) begin
            m[i] = (a[8*i +: 8] != b[8*i +: 8]);
        end
        return m;
    endfunction

    state_t            state_q;
    logic              halted_q;
    logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [LW-1:0]     level_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              data_error_q, err_sticky_q, ovf_q, udf_q;
    logic [NB-1:0]     mask_q;
    logic [CNT_W-1:0]  err_count_q, cmp_count_q, first_idx_q;
    logic [DATA_W-1:0] first_exp_q, first_act_q;

    logic              run, empty, full, pop, push, udf_ev, ovf_ev, mism, err_ev;
    logic [DATA_W-1:0] head, exp_word;
    logic [NB-1:0]     cmp_mask;

    // Pushes and pops are only honoured while RUN; emptiness is judged on the
    // occupancy at the start of the cycle, so a same-cycle push never feeds
    // the compare.
    always_comb begin
        run      = (state_q == RUN);
        empty    = (level_q == '0);
        full     = (level_q == LW'(DEPTH));
        pop      = run && bus.dout_vd && !empty;
        udf_ev   = run && bus.dout_vd && empty;
        // A pop in the same cycle frees the slot, so a push into a full FIFO
        // is accepted then.
        push     = run && bus.din_vd && (!full || pop);
        ovf_ev   = run && bus.din_vd && full && !pop;
        head     = mem_q[rd_ptr_q];
        cmp_mask = byte_diff(head, bus.dout_fifo);
        mism     = pop && (|cmp_mask);
        err_ev   = mism || udf_ev;
        exp_word = udf_ev ? '0 : head;
    end

    // Storage has no reset: only the pointers and occupancy define its content.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            halted_q     <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            level_q      <= '0;
            data_error_q <= 1'b0;
            err_sticky_q <= 1'b0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
            mask_q       <= '0;
            err_count_q  <= '0;
            cmp_count_q  <= '0;
            first_idx_q  <= '0;
            first_exp_q  <= '0;
            first_act_q  <= '0;
        end else if (clear) begin
            state_q      <= IDLE;
            halted_q     <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            level_q      <= '0;
            data_error_q <= 1'b0;
            err_sticky_q <= 1'b0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
            mask_q       <= '0;
            err_count_q  <= '0;
            cmp_count_q  <= '0;
            first_idx_q  <= '0;
            first_exp_q  <= '0;
            first_act_q  <= '0;
        end else begin
            data_error_q <= err_ev;

            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + AW'(1);
                mask_q      <= cmp_mask;
                cmp_count_q <= sat_inc(cmp_count_q);
            end
            if (udf_ev) begin
                mask_q <= '1;
                udf_q  <= 1'b1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            if (ovf_ev) begin
                ovf_q <= 1'b1;
            end

            if (err_ev) begin
                err_sticky_q <= 1'b1;
                err_count_q  <= sat_inc(err_count_q);
                // Only the very first error is captured; index is the
                // pre-increment compare count.
                if (!err_sticky_q) begin
                    first_exp_q <= exp_word;
                    first_act_q <= bus.dout_fifo;
                    first_idx_q <= cmp_count_q;
                end
            end

            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // Halting outranks dropping back to IDLE so the error is
                    // never lost when enable falls in the same cycle.
                    if (err_ev && (STOP_ON_ERR != 0)) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end else if (!enable) begin
                        state_q <= IDLE;
                    end
                end
                HALT:    state_q <= HALT;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_error    = data_error_q;
    assign err_byte_mask = mask_q;
    assign err_sticky    = err_sticky_q;
    assign ovf           = ovf_q;
    assign udf           = udf_q;
    assign halted        = halted_q;
    assign err_count     = err_count_q;
    assign cmp_count     = cmp_count_q;
    assign first_err_exp = first_exp_q;
    assign first_err_act = first_act_q;
    assign first_err_idx = first_idx_q;
    assign fifo_level    = level_q;

endmodule
